// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// Build option: CTRL_ILLEGAL_TRAP_EN (see multicycle_controller.sv).
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_READ_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // Opcode dispatch out of DECODE; anything unrecognised lands in ILLEGAL.
  function automatic state_e decode_dispatch(input logic [6:0] op_code);
    case (op_code)
      OP_LW, OP_SW: return S_MEM_ADR;
      OP_R:         return S_EXEC_R;
      OP_I:         return S_EXEC_I;
      OP_B:         return S_BRANCH;
      OP_JAL:       return S_JAL;
      default:      return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_ctrl_out_decode.sv
// Combinational state/opcode -> datapath selects and enables.
// Build option: CTRL_ILLEGAL_TRAP_EN decides whether ILLEGAL retires as a NOP.
module ctrl_out_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       rst_n,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr_en,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       instr_done
);

  // Per-state output decode; enables forced low while reset is asserted.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr_en  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALU_OUT;
    alu_op     = ALU_OP_ADD;
    imm_src    = IMM_I;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_B;
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (op_code == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        result_src = RES_READ_DATA;
        reg_wr_en  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
        imm_src   = IMM_I;
      end
      S_ALU_WB: begin
        reg_wr_en  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_OP_SUB;
        instr_done = 1'b1;
        case (funct3)
          3'b000:  pc_wr = zero;
          3'b001:  pc_wr = ~zero;
          default: pc_wr = 1'b0;
        endcase
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        pc_wr      = 1'b1;
        reg_wr_en  = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        instr_done = 1'b0;
`else
        instr_done = 1'b1;
`endif
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      reg_wr_en  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: state register, next-state logic, retire counter.
// Build option: CTRL_ILLEGAL_TRAP_EN makes ILLEGAL a sticky trap left only by reset;
// without it ILLEGAL retires as a NOP and illegal_o stays 0.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W     = 2,
  parameter int IMM_SRC_W    = 2,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [6:0]              op_code_i,
  input  logic [2:0]              funct3_i,
  input  logic                    zero_i,
  input  logic                    mem_ready_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic                    adr_src_o,
  output logic                    pc_wr_o,
  output logic                    ir_wr_o,
  output logic                    reg_wr_en_o,
  output logic [1:0]              alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [1:0]              result_src_o,
  output logic [ALU_OP_W-1:0]     alu_op_o,
  output logic [IMM_SRC_W-1:0]    imm_src_o,
  output logic                    instr_done_o,
  output logic [RETIRE_CNT_W-1:0] retired_o,
  output logic                    illegal_o
);

  state_e     state;
  state_e     state_next;
  logic       instr_done;
  logic [1:0] alu_op;
  logic [1:0] imm_src;

  ctrl_out_decode u_out_decode (
    .state      (state),
    .op_code    (op_code_i),
    .funct3     (funct3_i),
    .zero       (zero_i),
    .mem_ready  (mem_ready_i),
    .rst_n      (rst_ni),
    .mem_req    (mem_req_o),
    .mem_we     (mem_we_o),
    .adr_src    (adr_src_o),
    .pc_wr      (pc_wr_o),
    .ir_wr      (ir_wr_o),
    .reg_wr_en  (reg_wr_en_o),
    .alu_src_a  (alu_src_a_o),
    .alu_src_b  (alu_src_b_o),
    .result_src (result_src_o),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .instr_done (instr_done)
  );

  assign alu_op_o     = ALU_OP_W'(alu_op);
  assign imm_src_o    = IMM_SRC_W'(imm_src);
  assign instr_done_o = instr_done;

  // Next-state: memory states hold until the port reports ready.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (mem_ready_i) state_next = S_DECODE;
      S_DECODE:  state_next = decode_dispatch(op_code_i);
      S_MEM_ADR: state_next = (op_code_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_ready_i) state_next = S_MEM_WB;
      S_MEM_WB:  state_next = S_FETCH;
      S_MEM_WR:  if (mem_ready_i) state_next = S_FETCH;
      S_EXEC_R:  state_next = S_ALU_WB;
      S_EXEC_I:  state_next = S_ALU_WB;
      S_ALU_WB:  state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_JAL:     state_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_next = S_ILLEGAL;
`else
      S_ILLEGAL: state_next = S_FETCH;
`endif
      default:   state_next = S_FETCH;
    endcase
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= S_FETCH;
    else         state <= state_next;
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)         retired_o <= '0;
    else if (instr_done) retired_o <= retired_o + 1'b1;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag raised on entry to the trap state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                      illegal_q <= 1'b0;
    else if (state_next == S_ILLEGAL) illegal_q <= 1'b1;
  end

  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Honours CTRL_ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_multicycle_controller;

  // enables: {mem_req, mem_we, pc_wr, ir_wr, reg_wr_en, instr_done}
  localparam logic [5:0] EN_NONE  = 6'b000000;
  localparam logic [5:0] EN_REQ   = 6'b100000;
  localparam logic [5:0] EN_FGO   = 6'b101100;
  localparam logic [5:0] EN_WB    = 6'b000011;
  localparam logic [5:0] EN_WR    = 6'b110000;
  localparam logic [5:0] EN_WRGO  = 6'b110001;
  localparam logic [5:0] EN_BR_T  = 6'b001001;
  localparam logic [5:0] EN_DONE  = 6'b000001;
  localparam logic [5:0] EN_JAL   = 6'b001011;
  // selects: {adr_src, src_a, src_b, result_src, alu_op, imm_src}
  localparam logic [10:0] SEL_F    = 11'b0_00_10_00_00_00;
  localparam logic [10:0] SEL_D    = 11'b0_01_01_00_00_10;
  localparam logic [10:0] SEL_MA_L = 11'b0_10_01_00_00_00;
  localparam logic [10:0] SEL_MA_S = 11'b0_10_01_00_00_01;
  localparam logic [10:0] SEL_MEM  = 11'b1_00_00_00_00_00;
  localparam logic [10:0] SEL_MWB  = 11'b0_00_00_01_00_00;
  localparam logic [10:0] SEL_ER   = 11'b0_10_00_00_10_00;
  localparam logic [10:0] SEL_EI   = 11'b0_10_01_00_10_00;
  localparam logic [10:0] SEL_ZERO = 11'b0_00_00_00_00_00;
  localparam logic [10:0] SEL_BR   = 11'b0_10_00_00_01_00;
  localparam logic [10:0] SEL_JAL  = 11'b0_01_10_00_00_00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, mem_we, adr_src, pc_wr, ir_wr, reg_wr_en, instr_done, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op, imm_src;
  logic [3:0] retired4;

  logic       b_mem_req, b_mem_we, b_adr_src, b_pc_wr, b_ir_wr, b_reg_wr_en, b_instr_done, b_illegal;
  logic [1:0] b_alu_src_a, b_alu_src_b, b_result_src, b_alu_op, b_imm_src;
  logic [31:0] retired32;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;

  logic [5:0]  en_obs;
  logic [10:0] sel_obs;
  assign en_obs  = {mem_req, mem_we, pc_wr, ir_wr, reg_wr_en, instr_done};
  assign sel_obs = {adr_src, alu_src_a, alu_src_b, result_src, alu_op, imm_src};

  always #5 clk = ~clk;

  multicycle_controller #(.ALU_OP_W(2), .IMM_SRC_W(2), .RETIRE_CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .op_code_i(op_code), .funct3_i(funct3), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we), .adr_src_o(adr_src),
    .pc_wr_o(pc_wr), .ir_wr_o(ir_wr), .reg_wr_en_o(reg_wr_en), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .result_src_o(result_src), .alu_op_o(alu_op),
    .imm_src_o(imm_src), .instr_done_o(instr_done), .retired_o(retired4), .illegal_o(illegal)
  );

  multicycle_controller dut32 (
    .clk_i(clk), .rst_ni(rst_n), .op_code_i(op_code), .funct3_i(funct3), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .adr_src_o(b_adr_src),
    .pc_wr_o(b_pc_wr), .ir_wr_o(b_ir_wr), .reg_wr_en_o(b_reg_wr_en), .alu_src_a_o(b_alu_src_a),
    .alu_src_b_o(b_alu_src_b), .result_src_o(b_result_src), .alu_op_o(b_alu_op),
    .imm_src_o(b_imm_src), .instr_done_o(b_instr_done), .retired_o(retired32), .illegal_o(b_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One FSM cycle: drive ready, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic rdy, input logic [5:0] en, input logic [10:0] sel);
    mem_ready = rdy;
    #1;
    chk({tag, "_en"}, 32'(en_obs), 32'(en));
    chk({tag, "_sel"}, 32'(sel_obs), 32'(sel));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    logic [31:0] e;
    e = 32'(exp_ret);
    chk({tag, "_ret4"}, 32'(retired4), {28'd0, e[3:0]});
    chk({tag, "_ret32"}, retired32, e);
  endtask

  task automatic run_r(input string tag);
    op_code = 7'b0110011;
    cyc({tag, "_f"}, 1'b1, EN_FGO, SEL_F);
    cyc({tag, "_d"}, 1'b1, EN_NONE, SEL_D);
    cyc({tag, "_ex"}, 1'b1, EN_NONE, SEL_ER);
    cyc({tag, "_wb"}, 1'b1, EN_WB, 11'b0);
    exp_ret++;
  endtask

  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z, input logic [5:0] en);
    op_code = 7'b1100011;
    funct3  = f3;
    zero    = z;
    cyc({tag, "_f"}, 1'b1, EN_FGO, SEL_F);
    cyc({tag, "_d"}, 1'b1, EN_NONE, SEL_D);
    cyc({tag, "_br"}, 1'b1, en, SEL_BR);
    exp_ret++;
    chk_ret(tag);
  endtask

  initial begin
    rst_n = 1'b0; op_code = 7'b0110011; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset held with ready high: no enables even though FETCH is decoded.
    cyc("rst_hold", 1'b1, EN_NONE, SEL_F);
    chk_ret("rst");
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;

    // Fetch stall then R-type.
    for (int i = 0; i < 3; i++) cyc("f_stall", 1'b0, EN_REQ, SEL_F);
    cyc("f_go", 1'b1, EN_FGO, SEL_F);
    cyc("r_d", 1'b1, EN_NONE, SEL_D);
    cyc("r_ex", 1'b1, EN_NONE, SEL_ER);
    cyc("r_wb", 1'b1, EN_WB, 11'b0);
    exp_ret++;
    chk_ret("r1");

    // LW zero-wait: F, D, MA, MR, WB.
    op_code = 7'b0000011;
    cyc("lw_f", 1'b1, EN_FGO, SEL_F);
    cyc("lw_d", 1'b1, EN_NONE, SEL_D);
    cyc("lw_ma", 1'b1, EN_NONE, SEL_MA_L);
    cyc("lw_mr", 1'b1, EN_REQ, SEL_MEM);
    cyc("lw_wb", 1'b1, EN_WB, SEL_MWB);
    exp_ret++;
    chk_ret("lw");

    // SW with one wait cycle on the write.
    op_code = 7'b0100011;
    cyc("sw_f", 1'b1, EN_FGO, SEL_F);
    cyc("sw_d", 1'b1, EN_NONE, SEL_D);
    cyc("sw_ma", 1'b1, EN_NONE, SEL_MA_S);
    cyc("sw_wait", 1'b0, EN_WR, SEL_MEM);
    cyc("sw_go", 1'b1, EN_WRGO, SEL_MEM);
    exp_ret++;
    chk_ret("sw");

    // I-type.
    op_code = 7'b0010011;
    cyc("i_f", 1'b1, EN_FGO, SEL_F);
    cyc("i_d", 1'b1, EN_NONE, SEL_D);
    cyc("i_ex", 1'b1, EN_NONE, SEL_EI);
    cyc("i_wb", 1'b1, EN_WB, 11'b0);
    exp_ret++;
    chk_ret("i");

    // Branches.
    run_branch("beq_t", 3'b000, 1'b1, EN_BR_T);
    run_branch("bne_nt", 3'b001, 1'b1, EN_DONE);
    run_branch("bne_t", 3'b001, 1'b0, EN_BR_T);
    run_branch("beq_nt", 3'b000, 1'b0, EN_DONE);
    run_branch("blt_nt", 3'b100, 1'b1, EN_DONE);

    // JAL.
    op_code = 7'b1101111;
    cyc("jal_f", 1'b1, EN_FGO, SEL_F);
    cyc("jal_d", 1'b1, EN_NONE, SEL_D);
    cyc("jal_x", 1'b1, EN_JAL, SEL_JAL);
    exp_ret++;
    chk_ret("jal");

    // Reset in the middle of EXEC_R: no writeback, no count.
    op_code = 7'b0110011;
    cyc("rr_f", 1'b1, EN_FGO, SEL_F);
    cyc("rr_d", 1'b1, EN_NONE, SEL_D);
    rst_n = 1'b0;
    cyc("rr_ex", 1'b1, EN_NONE, SEL_ER);
    rst_n = 1'b1;
    exp_ret = 0;
    chk_ret("rr");
    cyc("rr_after", 1'b0, EN_REQ, SEL_F);

    // Counter wrap with 4-bit counter.
    for (int i = 0; i < 15; i++) run_r("wrap");
    chk_ret("wrap15");
    run_r("wrap16");
    chk_ret("wrap16");

    // Illegal opcode.
    op_code = 7'b1111111;
    cyc("ill_f", 1'b1, EN_FGO, SEL_F);
    cyc("ill_d", 1'b1, EN_NONE, SEL_D);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      cyc("ill_trap", 1'b1, EN_NONE, SEL_ZERO);
      chk("ill_flag", 32'(illegal), 32'd1);
    end
    chk_ret("ill_trap");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ill_cleared", 32'(illegal), 32'd0);
    op_code = 7'b0110011;
    cyc("ill_exit", 1'b0, EN_REQ, SEL_F);
`else
    cyc("ill_nop", 1'b1, EN_DONE, SEL_ZERO);
    exp_ret++;
    chk_ret("ill_nop");
    chk("ill_flag", 32'(illegal), 32'd0);
    op_code = 7'b0110011;
    cyc("ill_back", 1'b0, EN_REQ, SEL_F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
